// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - parametrised set-associative read-only instruction cache with Wishbone line refill
module icache_sa #(
   parameter int AW         = 16,
   parameter int WAYS       = 4,
   parameter int SETS       = 32,
   parameter int LINE_INSNS = 4,
   parameter int WBAW       = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            mem_req,
   input  logic            mem_ppl_submit,
   input  logic [AW-1:0]   mem_addr,
   output logic            mem_ack,
   output logic [31:0]     mem_data,
   output logic            mem_err,
   input  logic            i_flush,
   output logic            wb_cyc,
   output logic            wb_stb,
   output logic            wb_we,
   output logic [1:0]      wb_sel,
   output logic [WBAW-1:0] wb_adr,
   input  logic [15:0]     wb_i_dat,
   input  logic            wb_ack,
   input  logic            wb_err
);
   localparam int OFFW  = $clog2(LINE_INSNS);
   localparam int IDXW  = $clog2(SETS);
   localparam int TAGW  = AW - IDXW - OFFW;
   localparam int BEATS = 2 * LINE_INSNS;
   localparam int LINEW = 32 * LINE_INSNS;
   localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int BW    = OFFW + 1;

   typedef enum logic {S_IDLE, S_FILL} state_t;
   state_t state, state_n;

   logic             pending;
   logic [AW-1:0]    pend_addr;
   logic             lk_valid;
   logic [AW-1:0]    lk_addr;
   logic [AW-1:0]    fill_addr;
   logic [BW-1:0]    beat;
   logic [LINEW-1:0] fill_buf;
   logic [LINEW-1:0] fill_line;
   logic             fill_flushed;

   logic [WAYS-1:0]  valid    [SETS];
   logic [WW-1:0]    rr       [SETS];
   logic [TAGW-1:0]  tag_ram  [WAYS][SETS];
   logic [LINEW-1:0] data_ram [WAYS][SETS];
   logic [TAGW-1:0]  rd_tag   [WAYS];
   logic [LINEW-1:0] rd_line  [WAYS];

   logic [AW-1:0]    acc_addr;
   logic [IDXW-1:0]  acc_idx, lk_idx, fill_idx;
   logic [TAGW-1:0]  lk_tag, fill_tag;
   logic [OFFW-1:0]  lk_off, fill_off;
   logic             accept_ok, accept, hit, lookup_miss;
   logic             last_beat, beat_ack, fill_done;
   logic [LINEW-1:0] hit_line;
   logic [WW-1:0]    victim, rr_next;
   logic             set_full;

   // A parked request always goes ahead of a fresh submit
   assign acc_addr    = pending ? pend_addr : mem_addr;
   assign acc_idx     = acc_addr[OFFW+IDXW-1:OFFW];
   assign lk_tag      = lk_addr[AW-1:AW-TAGW];
   assign lk_idx      = lk_addr[OFFW+IDXW-1:OFFW];
   assign lk_off      = lk_addr[OFFW-1:0];
   assign fill_tag    = fill_addr[AW-1:AW-TAGW];
   assign fill_idx    = fill_addr[OFFW+IDXW-1:OFFW];
   assign fill_off    = fill_addr[OFFW-1:0];

   assign lookup_miss = lk_valid & ~hit;
   assign accept_ok   = mem_req & (state == S_IDLE) & ~lookup_miss;
   assign accept      = accept_ok & (mem_ppl_submit | pending);

   assign last_beat   = (beat == BW'(BEATS - 1));
   assign beat_ack    = (state == S_FILL) & wb_ack & ~wb_err;
   assign fill_done   = beat_ack & last_beat;

   assign wb_cyc      = (state == S_FILL);
   assign wb_stb      = (state == S_FILL);
   assign wb_we       = 1'b0;
   assign wb_sel      = 2'b11;
   assign wb_adr      = WBAW'({fill_addr[AW-1:OFFW], beat});

   // Tag compare across all ways against the registered RAM read
   always_comb begin
      hit      = 1'b0;
      hit_line = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid[lk_idx][w] && (rd_tag[w] == lk_tag)) begin
            hit      = 1'b1;
            hit_line = rd_line[w];
         end
      end
   end

   // Victim: lowest invalid way, otherwise the set's round-robin pointer
   always_comb begin
      victim   = rr[fill_idx];
      set_full = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[fill_idx][w]) begin
            victim   = WW'(w);
            set_full = 1'b0;
         end
      end
      rr_next = (rr[fill_idx] == WW'(WAYS - 1)) ? '0 : rr[fill_idx] + 1'b1;
   end

   // Assembled line with the final beat forwarded straight from the bus
   always_comb begin
      fill_line = fill_buf;
      fill_line[(BEATS-1)*16 +: 16] = wb_i_dat;
   end

   // Next state and fetch-side response
   always_comb begin
      state_n  = state;
      mem_ack  = 1'b0;
      mem_err  = 1'b0;
      mem_data = '0;
      case (state)
         S_IDLE: begin
            if (lk_valid) begin
               if (hit) begin
                  mem_ack  = 1'b1;
                  mem_data = hit_line[{lk_off, 5'b0} +: 32];
               end else begin
                  state_n = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (wb_err) begin
               mem_ack = 1'b1;
               mem_err = 1'b1;
               state_n = S_IDLE;
            end else if (wb_ack && last_beat) begin
               mem_ack  = 1'b1;
               mem_data = fill_line[{fill_off, 5'b0} +: 32];
               state_n  = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_n;
   end

   // Request tracking, refill bookkeeping, valid bits and round-robin pointers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pending      <= 1'b0;
         pend_addr    <= '0;
         lk_valid     <= 1'b0;
         lk_addr      <= '0;
         fill_addr    <= '0;
         beat         <= '0;
         fill_flushed <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            rr[s]    <= '0;
         end
      end else begin
         lk_valid <= accept;
         if (accept) begin
            lk_addr <= acc_addr;
            if (pending && mem_ppl_submit) pend_addr <= mem_addr;
            else                           pending   <= 1'b0;
         end else if (mem_ppl_submit) begin
            pending   <= 1'b1;
            pend_addr <= mem_addr;
         end

         if ((state == S_IDLE) && lookup_miss) begin
            fill_addr    <= lk_addr;
            beat         <= '0;
            fill_flushed <= 1'b0;
         end else if (state == S_FILL) begin
            if (beat_ack) beat <= beat + 1'b1;
            if (i_flush)  fill_flushed <= 1'b1;
         end

         // A flush in the install cycle wins over the install
         if (i_flush) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
         end else if (fill_done && !fill_flushed) begin
            valid[fill_idx][victim] <= 1'b1;
            if (set_full) rr[fill_idx] <= rr_next;
         end
      end
   end

   // Tag/data RAMs with one-cycle synchronous read, plus the refill line buffer
   always_ff @(posedge i_clk) begin
      if (accept) begin
         for (int w = 0; w < WAYS; w++) begin
            rd_tag[w]  <= tag_ram[w][acc_idx];
            rd_line[w] <= data_ram[w][acc_idx];
         end
      end
      if (beat_ack) fill_buf[{beat, 4'b0} +: 16] <= wb_i_dat;
      if (fill_done && !i_rst) begin
         tag_ram[victim][fill_idx]  <= fill_tag;
         data_ram[victim][fill_idx] <= fill_line;
      end
   end
endmodule

// File: tb/tb_icache_sa.sv
// tb/tb_icache_sa.sv - randomized self-checking bench for icache_sa against a set/way occupancy model
module tb_icache_sa;
   localparam int AW = 16, WAYS = 4, SETS = 32, LINE_INSNS = 4, WBAW = 16;
   localparam int OFFW = 2, IDXW = 5, BEATS = 8;

   logic            i_clk = 1'b0;
   logic            i_rst, mem_req, mem_ppl_submit, i_flush;
   logic [AW-1:0]   mem_addr;
   logic            mem_ack, mem_err;
   logic [31:0]     mem_data;
   logic            wb_cyc, wb_stb, wb_we;
   logic [1:0]      wb_sel;
   logic [WBAW-1:0] wb_adr;
   logic [15:0]     wb_i_dat;
   logic            wb_ack, wb_err;

   icache_sa #(.AW(AW), .WAYS(WAYS), .SETS(SETS), .LINE_INSNS(LINE_INSNS), .WBAW(WBAW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .mem_req(mem_req), .mem_ppl_submit(mem_ppl_submit),
      .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data), .mem_err(mem_err),
      .i_flush(i_flush), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
      .wb_adr(wb_adr), .wb_i_dat(wb_i_dat), .wb_ack(wb_ack), .wb_err(wb_err));

   always #5 i_clk = ~i_clk;

   int checks = 0, errors = 0;
   int cyc_n = 0, ack_total = 0, beat_in_cyc = 0, err_beat = -1, last_ack_cyc = 0;
   logic [15:0] adr_q[$];
   logic [31:0] rq_data[$];
   bit          rq_err[$];
   int          rq_cyc[$];

   // Model: which tags each set holds, plus the per-set replacement pointer
   int m_tag[SETS][WAYS];
   bit m_val[SETS][WAYS];
   int m_rr[SETS];

   function automatic logic [15:0] mw(input logic [15:0] wa);
      return (wa * 16'h9E37) ^ 16'h5A3C;
   endfunction

   function automatic logic [31:0] insn(input logic [AW-1:0] a);
      logic [15:0] w0;
      w0 = 16'(int'(a) * 2);
      return {mw(w0 + 16'd1), mw(w0)};
   endfunction

   function automatic bit m_hit(input logic [AW-1:0] a);
      int s, t;
      s = (int'(a) >> OFFW) % SETS;
      t = int'(a) >> (OFFW + IDXW);
      for (int w = 0; w < WAYS; w++) if (m_val[s][w] && m_tag[s][w] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_install(input logic [AW-1:0] a);
      int s, t, v;
      s = (int'(a) >> OFFW) % SETS;
      t = int'(a) >> (OFFW + IDXW);
      v = -1;
      for (int w = 0; w < WAYS; w++) if (!m_val[s][w] && v < 0) v = w;
      if (v < 0) begin
         v = m_rr[s];
         m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      m_tag[s][v] = t;
      m_val[s][v] = 1'b1;
   endtask

   task automatic m_clear(input bit with_rr);
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
         if (with_rr) m_rr[s] = 0;
      end
   endtask

   initial forever begin
      @(posedge i_clk);
      cyc_n++;
   end

   // Wishbone slave with random stalls and optional error on a chosen beat
   initial begin
      wb_ack = 1'b0; wb_err = 1'b0; wb_i_dat = '0;
      forever begin
         @(posedge i_clk); #1;
         wb_ack = 1'b0; wb_err = 1'b0; wb_i_dat = 16'($urandom);
         if (wb_cyc === 1'b1 && wb_stb === 1'b1 && $urandom_range(0, 3) != 0) begin
            last_ack_cyc = cyc_n;
            if (beat_in_cyc == err_beat) begin
               wb_err = 1'b1; err_beat = -1; beat_in_cyc = 0;
            end else begin
               wb_ack = 1'b1; wb_i_dat = mw(wb_adr); adr_q.push_back(wb_adr);
               ack_total++; beat_in_cyc = (beat_in_cyc + 1) % BEATS;
            end
         end
      end
   end

   initial forever begin
      @(negedge i_clk);
      if (mem_ack === 1'b1) begin
         rq_data.push_back(mem_data); rq_err.push_back(mem_err); rq_cyc.push_back(cyc_n);
      end
   end

   task automatic clear_q();
      adr_q.delete(); rq_data.delete(); rq_err.delete(); rq_cyc.delete();
   endtask

   task automatic do_fetch(input logic [AW-1:0] a, input string nm);
      bit exp_hit, exp_err, got;
      int b0, c0, eb, nb;
      logic [15:0] base;
      logic [31:0] d;
      bit e;
      int c;
      exp_hit = m_hit(a);
      eb      = err_beat;
      exp_err = !exp_hit && (eb >= 0);
      base    = 16'((int'(a) >> OFFW) * BEATS);
      clear_q();
      b0 = ack_total;
      @(posedge i_clk); #1;
      mem_addr = a; mem_ppl_submit = 1'b1; c0 = cyc_n;
      @(posedge i_clk); #1;
      mem_ppl_submit = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge i_clk);
         if (rq_data.size() > 0) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++; $display("FAIL %s timeout addr=%h got no mem_ack", nm, a);
         err_beat = -1;
         return;
      end
      d = rq_data.pop_front(); e = rq_err.pop_front(); c = rq_cyc.pop_front();
      nb = ack_total - b0;
      checks++;
      if (e !== exp_err) begin errors++; $display("FAIL %s mem_err addr=%h got %0b want %0b", nm, a, e, exp_err); end
      checks++;
      if (nb != (exp_hit ? 0 : (exp_err ? eb : BEATS))) begin
         errors++; $display("FAIL %s beats addr=%h got %0d want %0d", nm, a, nb, exp_hit ? 0 : (exp_err ? eb : BEATS));
      end
      checks++;
      if (c != (exp_hit ? c0 + 1 : last_ack_cyc)) begin
         errors++; $display("FAIL %s ack_cycle addr=%h got %0d want %0d", nm, a, c, exp_hit ? c0 + 1 : last_ack_cyc);
      end
      if (!exp_err) begin
         checks++;
         if (d !== insn(a)) begin errors++; $display("FAIL %s data addr=%h got %h want %h", nm, a, d, insn(a)); end
      end
      if (!exp_hit && !exp_err) begin
         for (int k = 0; k < BEATS && k < adr_q.size(); k++) begin
            checks++;
            if (adr_q[k] !== base + 16'(k)) begin
               errors++; $display("FAIL %s wb_adr beat %0d got %h want %h", nm, k, adr_q[k], base + 16'(k));
            end
         end
      end
      @(negedge i_clk);
      checks++;
      if (wb_cyc !== 1'b0) begin errors++; $display("FAIL %s wb_cyc_after got %0b want 0", nm, wb_cyc); end
      checks++;
      if (rq_data.size() != 0) begin errors++; $display("FAIL %s extra_acks got %0d want 0", nm, rq_data.size()); end
      if (!exp_hit && !exp_err) m_install(a);
      err_beat = -1;
   endtask

   task automatic do_flush();
      @(posedge i_clk); #1; i_flush = 1'b1;
      @(posedge i_clk); #1; i_flush = 1'b0;
      m_clear(1'b0);
   endtask

   task automatic test_reset();
      @(negedge i_clk); i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      err_beat = -1; beat_in_cyc = 0; clear_q(); m_clear(1'b1);
      @(negedge i_clk);
      checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL reset mem_ack got %0b want 0", mem_ack); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset mem_err got %0b want 0", mem_err); end
      checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL reset cyc_stb got %0b%0b want 00", wb_cyc, wb_stb); end
      checks++; if (wb_we !== 1'b0 || wb_sel !== 2'b11) begin errors++; $display("FAIL reset we_sel got %0b/%b want 0/11", wb_we, wb_sel); end
   endtask

   task automatic test_eviction();
      do_fetch(16'h0090, "evict_fill1");
      do_fetch(16'h0110, "evict_fill2");
      do_fetch(16'h0190, "evict_fill3");
      do_fetch(16'h0210, "evict_victim");
      do_fetch(16'h0090, "evict_survivor");
      do_fetch(16'h0010, "evict_evicted");
   endtask

   task automatic test_flush();
      int b0;
      do_flush();
      do_fetch(16'h0011, "flush_refetch");
      clear_q(); b0 = ack_total;
      @(posedge i_clk); #1; mem_addr = 16'h0090; mem_ppl_submit = 1'b1;
      @(posedge i_clk); #1; mem_ppl_submit = 1'b0;
      for (int i = 0; i < 200 && (ack_total - b0) < 3; i++) @(negedge i_clk);
      @(posedge i_clk); #1; i_flush = 1'b1;
      @(posedge i_clk); #1; i_flush = 1'b0;
      m_clear(1'b0);
      for (int i = 0; i < 200 && rq_data.size() == 0; i++) @(negedge i_clk);
      checks++;
      if (rq_data.size() != 1 || rq_data[0] !== insn(16'h0090) || rq_err[0] !== 1'b0) begin
         errors++; $display("FAIL flush_mid_fill resp count=%0d data=%h want 1 %h", rq_data.size(),
                            rq_data.size() > 0 ? rq_data[0] : 32'h0, insn(16'h0090));
      end
      do_fetch(16'h0090, "flush_mid_refetch");
   endtask

   task automatic test_bus_error();
      err_beat = 3;
      do_fetch(16'h0040, "err_fill");
      do_fetch(16'h0040, "err_refetch");
   endtask

   task automatic test_back_to_back();
      int b0;
      do_fetch(16'h0100, "b2b_prefill");
      clear_q(); b0 = ack_total;
      @(posedge i_clk); #1; mem_addr = 16'h0064; mem_ppl_submit = 1'b1;
      @(posedge i_clk); #1; mem_ppl_submit = 1'b0;
      for (int i = 0; i < 200 && (ack_total - b0) < 2; i++) @(negedge i_clk);
      @(posedge i_clk); #1; mem_addr = 16'h0100; mem_ppl_submit = 1'b1;
      @(posedge i_clk); #1; mem_ppl_submit = 1'b0;
      for (int i = 0; i < 400 && rq_data.size() < 2; i++) @(negedge i_clk);
      repeat (2) @(negedge i_clk);
      checks++;
      if (rq_data.size() != 2) begin
         errors++; $display("FAIL b2b resp_count got %0d want 2", rq_data.size());
      end else begin
         checks++;
         if (rq_data[0] !== insn(16'h0064)) begin errors++; $display("FAIL b2b first_data got %h want %h", rq_data[0], insn(16'h0064)); end
         checks++;
         if (rq_data[1] !== insn(16'h0100)) begin errors++; $display("FAIL b2b second_data got %h want %h", rq_data[1], insn(16'h0100)); end
         checks++;
         if (rq_cyc[1] != rq_cyc[0] + 2) begin errors++; $display("FAIL b2b second_latency got %0d want %0d", rq_cyc[1], rq_cyc[0] + 2); end
      end
      checks++;
      if (ack_total - b0 != BEATS) begin errors++; $display("FAIL b2b beats got %0d want %0d", ack_total - b0, BEATS); end
      m_install(16'h0064);
   endtask

   task automatic test_reset_mid_fill();
      int b0;
      clear_q(); b0 = ack_total;
      @(posedge i_clk); #1; mem_addr = 16'h0400; mem_ppl_submit = 1'b1;
      @(posedge i_clk); #1; mem_ppl_submit = 1'b0;
      for (int i = 0; i < 200 && (ack_total - b0) < 2; i++) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL rst_fill wb_cyc got %0b want 0", wb_cyc); end
      @(negedge i_clk);
      i_rst = 1'b0;
      checks++; if (rq_data.size() != 0) begin errors++; $display("FAIL rst_fill acks got %0d want 0", rq_data.size()); end
      beat_in_cyc = 0; err_beat = -1; m_clear(1'b1);
      do_fetch(16'h0400, "rst_refetch");
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            do_flush();
         end else begin
            a = 16'(($urandom_range(0, 5) << 7) | ((4 + $urandom_range(0, 1)) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) err_beat = int'($urandom_range(0, BEATS - 1));
            do_fetch(a, "rand");
         end
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1; mem_req = 1'b1; mem_ppl_submit = 1'b0; i_flush = 1'b0; mem_addr = '0;
      test_reset();
      do_fetch(16'h0010, "first_miss");
      do_fetch(16'h0011, "first_hit");
      test_eviction();
      test_flush();
      test_bus_error();
      test_back_to_back();
      test_reset_mid_fill();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
